// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU control path.
//   - opcode_e : 4-bit instruction opcodes (NOP..HLT; 0xC-0xF undefined)
//   - ALU_*    : 3-bit ALU function selects, shared with the ALU
//   - state_e  : sequencer states
//   - dec_t    : decoded EXEC strobes produced by cpu_opcode_decode
//   - OPC_MSB/OPC_LSB : opcode field position inside the instruction byte
package cpu_pkg;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_MOV = 4'h7,
    OP_LDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_HLT = 4'hB
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_PAUSE, S_HALT
  } state_e;

  typedef struct packed {
    logic       acc_load;
    logic       rf_write;
    logic       imm;
    logic       pc_load;
    logic [2:0] alu_op;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Combinational opcode decoder.
//   opcode_i : instruction opcode field
//   zero_i   : accumulator-zero flag (qualifies JZ)
//   dec_o    : {acc_load, rf_write, imm, pc_load, alu_op, illegal}
module cpu_opcode_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_NOP, OP_HLT: ;
      OP_ADD: begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_ADD; end
      OP_SUB: begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_SUB; end
      OP_AND: begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_AND; end
      OP_OR:  begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_OR;  end
      OP_XOR: begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_XOR; end
      OP_NOT: begin dec_o.acc_load = 1'b1; dec_o.alu_op = ALU_NOT; end
      OP_MOV: dec_o.rf_write = 1'b1;
      OP_LDI: begin dec_o.rf_write = 1'b1; dec_o.imm = 1'b1; end
      OP_JMP: dec_o.pc_load = 1'b1;
      OP_JZ:  dec_o.pc_load = zero_i;
      default: dec_o.illegal = 1'b1;  // 0xC-0xF execute as NOP
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer with run/halt/single-step
// control and a retired-instruction counter.
//   clk, reset        : clock, synchronous active-high reset
//   start, step_mode  : leave IDLE/PAUSE/HALT; pause after each instruction
//   instruction       : ROM byte at current PC, acc_zero : datapath flag
//   ir_load, pc_enable, pc_load, acc_load, rf_write, imm, alu_op : strobes
//   busy, halted, illegal (sticky), retired : status
// All outputs are registers loaded from the next-state decode, so each
// output is valid exactly during the state it belongs to.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step_mode,
  input  logic [7:0]          instruction,
  input  logic                acc_zero,
  output logic                ir_load,
  output logic                pc_enable,
  output logic                pc_load,
  output logic                acc_load,
  output logic                rf_write,
  output logic                imm,
  output logic [2:0]          alu_op,
  output logic                busy,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_e              state_q, state_d;
  logic [3:0]          opc_q, opc_d;
  dec_t                exe_q, exe_d;
  logic                ir_load_q, ir_load_d;
  logic                pc_enable_q, pc_enable_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  dec_t                dec;

  // Operand field is consumed by the datapath, not here.
  logic unused_operand;
  assign unused_operand = ^instruction[OPC_LSB-1:0];

  // Decoded on the DECODE->EXEC edge from the same opcode and zero flag
  // that are latched on that edge; the JZ zero-flag decision lives on in
  // exe_q.pc_load, which also suppresses the WB increment.
  cpu_opcode_decode u_dec (
    .opcode_i (instruction[OPC_MSB:OPC_LSB]),
    .zero_i   (acc_zero),
    .dec_o    (dec)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PAUSE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (opc_q == OP_HLT) state_d = S_HALT;
        else if (step_mode)  state_d = S_PAUSE;
        else                 state_d = S_FETCH;
      end
      default:  state_d = S_IDLE;
    endcase

    opc_d       = (state_q == S_DECODE) ? instruction[OPC_MSB:OPC_LSB] : opc_q;
    exe_d       = (state_d == S_EXEC) ? dec : '0;
    ir_load_d   = (state_d == S_FETCH);
    // state_d==WB only follows EXEC, where exe_q holds the jump decision.
    pc_enable_d = (state_d == S_WB) && !exe_q.pc_load;
    busy_d      = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                  (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d    = (state_d == S_HALT);
    illegal_d   = illegal_q | exe_d.illegal;
    retired_d   = retired_q + ((state_q == S_WB) ? RETIRE_W'(1) : RETIRE_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opc_q       <= 4'h0;
      exe_q       <= '0;
      ir_load_q   <= 1'b0;
      pc_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      exe_q       <= exe_d;
      ir_load_q   <= ir_load_d;
      pc_enable_q <= pc_enable_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign ir_load   = ir_load_q;
  assign pc_enable = pc_enable_q;
  assign pc_load   = exe_q.pc_load;
  assign acc_load  = exe_q.acc_load;
  assign rf_write  = exe_q.rf_write;
  assign imm       = exe_q.imm;
  assign alu_op    = exe_q.alu_op;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 4-bit microprocessor datapath. It steps the shared program counter, ROM, register file, ALU and accumulator through a fixed FETCH/DECODE/EXEC/WB cycle per instruction. It also adds run/halt/single-step control and a retired-instruction counter. It replaces the single-cycle control path and drives the existing PC, register-file and accumulator enables directly.

## Interface
Parameters:
- `RETIRE_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; leaves IDLE, PAUSE or HALT.
- `step_mode`  in  1  level; when 1, the sequencer pauses after every retired instruction.
- `instruction`  in  8  ROM output at the current PC; `[7:4]` is the opcode.
- `acc_zero`  in  1  accumulator == 0, from the datapath.
- `ir_load`  out  1  capture `instruction` into the instruction register.
- `pc_enable`  out  1  PC += 1 (4-bit, wraps 15 -> 0).
- `pc_load`  out  1  PC <= `instruction[3:0]`.
- `acc_load`  out  1  accumulator <= ALU result.
- `rf_write`  out  1  register-file write.
- `imm`  out  1  register-file write data is the immediate field.
- `alu_op`  out  3  ALU function select.
- `busy`  out  1  high in FETCH, DECODE, EXEC and WB.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on any undefined opcode.
- `retired`  out  RETIRE_W  count of completed instructions; wraps.

## Operation
- States:
  - IDLE: the reset state.
  - FETCH: `ir_load=1`. Go to DECODE.
  - DECODE: latch the opcode and `acc_zero`. Go to EXEC.
  - EXEC: assert the strobes for the opcode (see below). Go to WB.
  - WB: `pc_enable=1` unless a jump was taken; `retired++`. Go to PAUSE if `step_mode`, HALT if the opcode was HLT, otherwise FETCH.
  - PAUSE: wait for `start`.
  - HALT: wait for `start`.
- IDLE, PAUSE and HALT all go to FETCH on `start`. The PC is untouched by the transition.
- Opcode actions in EXEC:
  - 0 NOP: none.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT: `acc_load=1`, `alu_op` = opcode−1 (values 0..5).
  - 7 MOV: `rf_write=1`, `imm=0`.
  - 8 LDI: `rf_write=1`, `imm=1`.
  - 9 JMP: `pc_load=1`.
  - A JZ: `pc_load=1` only if the latched `acc_zero` is 1.
  - B HLT: none. The PC still increments in WB, so `start` resumes at the next instruction.
  - C–F: treated as NOP and set `illegal`. `illegal` clears only on reset.
- `alu_op` is held at 0 outside EXEC.
- All strobes are zero outside the states named above.
- At most one of `acc_load`, `rf_write` and `pc_load` is high in any cycle.
- `pc_enable` and `pc_load` are never high in the same cycle.

## Timing
- Every output is registered and decoded from state plus latched opcode. There is no combinational path from input to output.
- Every instruction takes exactly 4 cycles: FETCH, DECODE, EXEC, WB.
- The first FETCH is the cycle after `start` is sampled.
- Reset values: state IDLE, every strobe 0, `busy=0`, `halted=0`, `illegal=0`, `retired=0`, latched opcode 0.
- `reset` overrides everything, including mid-instruction. There is no partial writeback after a reset.
- `start` is ignored while `busy`.
- If `start` and `reset` are high in the same cycle, `reset` wins.
- `step_mode` is sampled only in WB. Changing it mid-instruction takes effect at the next WB.
- HLT with `step_mode=1` goes to HALT, not PAUSE.
- `retired` wraps from all-ones to 0.

## Structure
- Shared package `cpu_pkg`:
  - 4-bit opcode enum (NOP..HLT).
  - 3-bit ALU op constants.
  - state enum.
  - instruction field slices (`OPC_MSB`/`OPC_LSB`).
- The ALU module imports the same ALU op constants.
- One sub-module: `cpu_opcode_decode`, a combinational mapping from opcode and latched zero flag to `{acc_load, rf_write, imm, pc_load, alu_op, illegal}`. The FSM registers its outputs in EXEC.

## Test plan
- Reset, then `start`: `ir_load` high in cycle 1. With NOP, `pc_enable` is high in cycle 4 only and `retired`=1 after the WB edge.
- `instruction`=0x2_3 (SUB): `acc_load=1` and `alu_op`=1 in EXEC only. All other strobes stay 0.
- JZ 0x5 with `acc_zero`=1: `pc_load=1` in EXEC and `pc_enable=0` in WB. Repeat with `acc_zero`=0: `pc_load=0` and `pc_enable=1`.
- HLT: `halted`=1 from the cycle after WB and `busy`=0. `start` pulses while busy are ignored. `start` in HALT gives FETCH the next cycle.
- `step_mode=1` over three NOPs: PAUSE after each, with exactly 4 busy cycles per `start`. `retired` counts 1, 2, 3.
- Opcode 0xE: `illegal` goes to 1 and stays 1 across later legal instructions. Asserting `reset` during EXEC of an ADD gives no `acc_load` next cycle and all outputs at reset values.
